// File: rtl/execute_stage_mc_if.sv
// D/X-to-X/M bundle for the execute stage: operand, bypass and control inputs,
// redirect and stall outputs, and the registered X/M latch contents.
interface execute_stage_mc_if #(
   parameter int WIDTH = 32
);
   logic [31:0]      insn_in;
   logic             insn_valid;
   logic [WIDTH-1:0] pc_plus1;
   logic [WIDTH-1:0] regfile_a;
   logic [WIDTH-1:0] regfile_b;
   logic [WIDTH-1:0] o_xm_out;
   logic [WIDTH-1:0] data_writeReg;
   logic [1:0]       byp_a;
   logic [1:0]       byp_b;
   logic             flush;
   logic             stall;
   logic [WIDTH-1:0] pc_next;
   logic             branched_jumped;
   logic [31:0]      xm_insn;
   logic [WIDTH-1:0] xm_o;
   logic [WIDTH-1:0] xm_b;
   logic             xm_valid;
   logic             xm_exception;

   modport master (
      output insn_in, insn_valid, pc_plus1, regfile_a, regfile_b,
             o_xm_out, data_writeReg, byp_a, byp_b, flush,
      input  stall, pc_next, branched_jumped,
             xm_insn, xm_o, xm_b, xm_valid, xm_exception
   );

   modport slave (
      input  insn_in, insn_valid, pc_plus1, regfile_a, regfile_b,
             o_xm_out, data_writeReg, byp_a, byp_b, flush,
      output stall, pc_next, branched_jumped,
             xm_insn, xm_o, xm_b, xm_valid, xm_exception
   );
endinterface

// File: rtl/execute_stage_mc.sv
// Execute stage with MX/WX bypassing, branch/jump resolution and the X/M latch.
// Define EXEC_MULDIV_EN for the iterative mul/div unit; otherwise mul/div trap at once.
module execute_stage_mc #(
   parameter int WIDTH = 32
) (
   input  logic              clock,
   input  logic              reset,
   execute_stage_mc_if.slave bus
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   localparam logic [WIDTH-1:0] EXC_ADD  = WIDTH'(1);
   localparam logic [WIDTH-1:0] EXC_ADDI = WIDTH'(2);
   localparam logic [WIDTH-1:0] EXC_SUB  = WIDTH'(3);
   localparam logic [WIDTH-1:0] EXC_MUL  = WIDTH'(4);
   localparam logic [WIDTH-1:0] EXC_DIV  = WIDTH'(5);

   logic [31:0]      insn;
   logic [4:0]       opcode;
   logic [4:0]       alu_op;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] imm_sext;
   logic [WIDTH-1:0] jump_target;
   logic [WIDTH-1:0] setx_val;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic             is_rtype;
   logic             is_mul;
   logic             is_div;
   logic             is_muldiv;
   logic             use_imm;
   logic [WIDTH-1:0] sc_result;
   logic             sc_exc;
   logic [WIDTH-1:0] ex_result;
   logic             ex_exc;
   logic             take;
   logic [WIDTH-1:0] target;
   logic             redirect_ok;
   logic             stall_int;
   logic             load_bubble;

   logic [31:0]      xm_insn_q;
   logic [WIDTH-1:0] xm_o_q;
   logic [WIDTH-1:0] xm_b_q;
   logic             xm_valid_q;
   logic             xm_exception_q;

   assign insn        = bus.insn_in;
   assign opcode      = insn[31:27];
   assign alu_op      = insn[6:2];
   assign shamt       = SHW'(insn[11:7]);
   assign imm_sext    = {{(WIDTH-17){insn[16]}}, insn[16:0]};
   assign jump_target = {bus.pc_plus1[WIDTH-1:27], insn[26:0]};
   assign setx_val    = {{(WIDTH-27){1'b0}}, insn[26:0]};

   assign is_rtype  = (opcode == OP_RTYPE);
   assign is_mul    = is_rtype && (alu_op == ALU_MUL);
   assign is_div    = is_rtype && (alu_op == ALU_DIV);
   assign is_muldiv = is_mul || is_div;
   assign use_imm   = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);

   // Bypass selection; code 11 falls through to the MX source.
   always_comb begin
      case (bus.byp_a)
         2'b00:   op_a = bus.regfile_a;
         2'b01:   op_a = bus.data_writeReg;
         default: op_a = bus.o_xm_out;
      endcase
      case (bus.byp_b)
         2'b00:   op_b = bus.regfile_b;
         2'b01:   op_b = bus.data_writeReg;
         default: op_b = bus.o_xm_out;
      endcase
   end

   assign alu_b   = use_imm ? imm_sext : op_b;
   assign sum     = op_a + alu_b;
   assign diff    = op_a - op_b;
   assign add_ovf = (op_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
   assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);

   always_comb begin
      sc_result = '0;
      sc_exc    = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (alu_op)
               ALU_ADD: begin
                  sc_result = add_ovf ? EXC_ADD : sum;
                  sc_exc    = add_ovf;
               end
               ALU_SUB: begin
                  sc_result = sub_ovf ? EXC_SUB : diff;
                  sc_exc    = sub_ovf;
               end
               ALU_AND: sc_result = op_a & op_b;
               ALU_OR:  sc_result = op_a | op_b;
               ALU_SLL: sc_result = op_a << shamt;
               ALU_SRA: sc_result = $signed(op_a) >>> shamt;
               ALU_MUL: begin
                  sc_result = EXC_MUL;
                  sc_exc    = 1'b1;
               end
               ALU_DIV: begin
                  sc_result = EXC_DIV;
                  sc_exc    = 1'b1;
               end
               default: ;
            endcase
         end
         OP_ADDI: begin
            sc_result = add_ovf ? EXC_ADDI : sum;
            sc_exc    = add_ovf;
         end
         OP_LW, OP_SW: sc_result = sum;
         OP_JAL:       sc_result = bus.pc_plus1;
         OP_SETX:      sc_result = setx_val;
         default: ;
      endcase
   end

   always_comb begin
      take   = 1'b0;
      target = '0;
      case (opcode)
         OP_BNE: begin
            take   = (op_a != op_b);
            target = bus.pc_plus1 + imm_sext;
         end
         OP_BLT: begin
            take   = ($signed(op_b) < $signed(op_a));
            target = bus.pc_plus1 + imm_sext;
         end
         OP_J, OP_JAL: begin
            take   = 1'b1;
            target = jump_target;
         end
         OP_JR: begin
            take   = 1'b1;
            target = op_b;
         end
         OP_BEX: begin
            take   = (op_a != '0);
            target = jump_target;
         end
         default: ;
      endcase
   end

   assign redirect_ok         = bus.insn_valid && !stall_int && !bus.flush;
   assign bus.branched_jumped = redirect_ok && take;
   assign bus.pc_next         = redirect_ok ? target : '0;
   assign bus.stall           = stall_int;

`ifdef EXEC_MULDIV_EN
   localparam int CNTW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

   md_state_t          md_state;
   md_state_t          md_state_nxt;
   logic               md_start;
   logic               md_last;
   logic [CNTW-1:0]    step_cnt;
   logic               md_is_div;
   logic               md_neg;
   logic               md_special;
   logic [WIDTH-1:0]   md_hi;
   logic [WIDTH-1:0]   md_lo;
   logic [WIDTH-1:0]   md_mag_b;
   logic [WIDTH-1:0]   md_hi_nxt;
   logic [WIDTH-1:0]   md_lo_nxt;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic               div_ge;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] mul_signed;
   logic [WIDTH:0]     mul_top;
   logic               mul_ovf;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   md_result;
   logic               md_exc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) md_state <= MD_IDLE;
      else       md_state <= md_state_nxt;
   end

   assign md_last = (step_cnt == CNTW'(WIDTH - 1));

   always_comb begin
      md_state_nxt = md_state;
      case (md_state)
         MD_IDLE: if (md_start) md_state_nxt = MD_BUSY;
         MD_BUSY: if (md_last)  md_state_nxt = MD_DONE;
         MD_DONE: md_state_nxt = MD_IDLE;
         default: md_state_nxt = MD_IDLE;
      endcase
      if (bus.flush) md_state_nxt = MD_IDLE;
   end

   // Flush wins over everything, so stall can drop in the very cycle it arrives.
   always_comb begin
      md_start  = (md_state == MD_IDLE) && bus.insn_valid && is_muldiv && !bus.flush;
      stall_int = md_start || ((md_state == MD_BUSY) && !bus.flush);
   end

   // Mul shifts the product right through {hi, lo}; div shifts the quotient in through lo.
   always_comb begin
      mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_mag_b} : '0);
      div_shift = {md_hi, md_lo[WIDTH-1]};
      div_trial = div_shift - {1'b0, md_mag_b};
      div_ge    = !div_trial[WIDTH];
      if (md_is_div) begin
         md_hi_nxt = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
         md_lo_nxt = {md_lo[WIDTH-2:0], div_ge};
      end else begin
         md_hi_nxt = mul_sum[WIDTH:1];
         md_lo_nxt = {mul_sum[0], md_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         step_cnt   <= '0;
         md_is_div  <= 1'b0;
         md_neg     <= 1'b0;
         md_special <= 1'b0;
         md_hi      <= '0;
         md_lo      <= '0;
         md_mag_b   <= '0;
      end else if (md_start) begin
         step_cnt   <= '0;
         md_is_div  <= is_div;
         md_neg     <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
         md_special <= is_div && ((op_b == '0) || ((op_a == SMIN) && (op_b == '1)));
         md_hi      <= '0;
         md_lo      <= op_a[WIDTH-1] ? -op_a : op_a;
         md_mag_b   <= op_b[WIDTH-1] ? -op_b : op_b;
      end else if (md_state == MD_BUSY) begin
         step_cnt   <= step_cnt + 1'b1;
         md_hi      <= md_hi_nxt;
         md_lo      <= md_lo_nxt;
      end
   end

   always_comb begin
      product    = {md_hi, md_lo};
      mul_signed = md_neg ? -product : product;
      mul_top    = mul_signed[2*WIDTH-1:WIDTH-1];
      mul_ovf    = !((&mul_top) || !(|mul_top));
      quotient   = md_neg ? -md_lo : md_lo;
      if (md_is_div) begin
         md_result = md_special ? EXC_DIV : quotient;
         md_exc    = md_special;
      end else begin
         md_result = mul_ovf ? EXC_MUL : mul_signed[WIDTH-1:0];
         md_exc    = mul_ovf;
      end
   end

   assign ex_result = is_muldiv ? md_result : sc_result;
   assign ex_exc    = is_muldiv ? md_exc    : sc_exc;
`else
   assign stall_int = 1'b0;
   assign ex_result = sc_result;
   assign ex_exc    = sc_exc;
`endif

   assign load_bubble = !bus.insn_valid || bus.flush || stall_int;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         xm_insn_q      <= '0;
         xm_o_q         <= '0;
         xm_b_q         <= '0;
         xm_valid_q     <= 1'b0;
         xm_exception_q <= 1'b0;
      end else if (load_bubble) begin
         xm_insn_q      <= '0;
         xm_o_q         <= '0;
         xm_b_q         <= '0;
         xm_valid_q     <= 1'b0;
         xm_exception_q <= 1'b0;
      end else begin
         xm_insn_q      <= insn;
         xm_o_q         <= ex_result;
         xm_b_q         <= op_b;
         xm_valid_q     <= 1'b1;
         xm_exception_q <= ex_exc;
      end
   end

   assign bus.xm_insn      = xm_insn_q;
   assign bus.xm_o         = xm_o_q;
   assign bus.xm_b         = xm_b_q;
   assign bus.xm_valid     = xm_valid_q;
   assign bus.xm_exception = xm_exception_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Scoreboard bench for execute_stage_mc: directed vectors push expected X/M contents,
// an independent monitor pops them whenever xm_valid is seen.
module tb_execute_stage_mc;

   localparam int WIDTH = 32;

   logic clock = 1'b0;
   logic reset;

   execute_stage_mc_if #(.WIDTH(WIDTH)) bus();

   execute_stage_mc #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [31:0] insn;
      logic [31:0] o;
      logic        chk_o;
      logic [31:0] b;
      logic        exc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] rtype(input logic [4:0] alu, input logic [4:0] sh);
      return {15'd0, 5'd0, sh, alu, 2'b00};
   endfunction

   function automatic logic [31:0] itype(input logic [4:0] op, input logic [16:0] imm);
      return {op, 10'd0, imm};
   endfunction

   function automatic logic [31:0] jtype(input logic [4:0] op, input logic [26:0] t);
      return {op, t};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every valid X/M word must match the oldest outstanding expectation.
   always @(negedge clock) begin
      exp_t e;
      if (!reset && bus.xm_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got xm_insn 0x%0h, expected no output", bus.xm_insn);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, ".insn"}, bus.xm_insn, e.insn);
            if (e.chk_o) checkOutput({e.name, ".o"}, bus.xm_o, e.o);
            checkOutput({e.name, ".b"}, bus.xm_b, e.b);
            checkOutput({e.name, ".exc"}, bus.xm_exception, e.exc);
         end
      end
   end

   task automatic applyStimulus(input string name, input logic [31:0] insn,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                                input logic exp_br, input logic [31:0] exp_pc,
                                input logic chk_o, input logic [31:0] exp_o,
                                input logic exp_exc, input logic [31:0] exp_b);
      exp_t e;
      bus.insn_in    = insn;
      bus.insn_valid = 1'b1;
      bus.regfile_a  = a;
      bus.regfile_b  = b;
      bus.pc_plus1   = pc;
      #1;
      checkOutput({name, ".stall"}, bus.stall, 0);
      checkOutput({name, ".br"}, bus.branched_jumped, exp_br);
      if (exp_br) checkOutput({name, ".pc_next"}, bus.pc_next, exp_pc);
      e = '{name, insn, exp_o, chk_o, exp_b, exp_exc};
      sb.push_back(e);
      @(posedge clock);
      #1;
      bus.insn_valid = 1'b0;
      bus.byp_a      = 2'b00;
      bus.byp_b      = 2'b00;
      bus.flush      = 1'b0;
   endtask

   task automatic aluOp(input string name, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_o, input logic exp_exc);
      applyStimulus(name, insn, a, b, 32'd0, 1'b0, 32'd0, 1'b1, exp_o, exp_exc, b);
   endtask

   task automatic brOp(input string name, input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic exp_br, input logic [31:0] exp_pc);
      applyStimulus(name, insn, a, b, pc, exp_br, exp_pc, 1'b0, 32'd0, 1'b0, b);
   endtask

`ifdef EXEC_MULDIV_EN
   task automatic runMulDiv(input string name, input logic [31:0] insn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_o, input logic exp_exc);
      exp_t e;
      bus.insn_in    = insn;
      bus.insn_valid = 1'b1;
      bus.regfile_a  = a;
      bus.regfile_b  = b;
      #1;
      checkOutput({name, ".stall_c0"}, bus.stall, 1);
      e = '{name, insn, exp_o, 1'b1, b, exp_exc};
      sb.push_back(e);
      for (int c = 1; c <= WIDTH; c++) begin
         @(posedge clock);
         #1;
         bus.regfile_a     = 32'hDEAD_0000 + c;
         bus.regfile_b     = 32'hBEEF_0000 + c;
         bus.byp_a         = 2'b01;
         bus.data_writeReg = 32'h0000_0000 + c;
         #1;
         checkOutput($sformatf("%s.stall_c%0d", name, c), bus.stall, 1);
      end
      @(posedge clock);
      #1;
      bus.regfile_a = a;
      bus.regfile_b = b;
      bus.byp_a     = 2'b00;
      #1;
      checkOutput({name, ".stall_done"}, bus.stall, 0);
      @(posedge clock);
      #1;
      bus.insn_valid = 1'b0;
   endtask
`endif

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset             = 1'b1;
      bus.insn_in       = '0;
      bus.insn_valid    = 1'b0;
      bus.pc_plus1      = '0;
      bus.regfile_a     = '0;
      bus.regfile_b     = '0;
      bus.o_xm_out      = '0;
      bus.data_writeReg = '0;
      bus.byp_a         = 2'b00;
      bus.byp_b         = 2'b00;
      bus.flush         = 1'b0;
      #2;
      checkOutput("reset.stall", bus.stall, 0);
      checkOutput("reset.xm_valid", bus.xm_valid, 0);
      checkOutput("reset.xm_o", bus.xm_o, 0);
      checkOutput("reset.xm_insn", bus.xm_insn, 0);
      checkOutput("reset.xm_exc", bus.xm_exception, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      aluOp("add_ovf", rtype(5'd0, 5'd0), 32'h7FFF_FFFF, 32'd1, 32'd1, 1'b1);
      aluOp("add", rtype(5'd0, 5'd0), 32'd2, 32'd3, 32'd5, 1'b0);
      bus.byp_a = 2'b10; bus.o_xm_out = 32'd5;
      bus.byp_b = 2'b01; bus.data_writeReg = 32'd3;
      applyStimulus("sub_bypass", rtype(5'd1, 5'd0), 32'd100, 32'd200, 32'd0,
                    1'b0, 32'd0, 1'b1, 32'd2, 1'b0, 32'd3);
      bus.byp_a = 2'b11; bus.o_xm_out = 32'd9;
      aluOp("add_byp11", rtype(5'd0, 5'd0), 32'd100, 32'd1, 32'd10, 1'b0);
      aluOp("sub_ovf", rtype(5'd1, 5'd0), 32'h8000_0000, 32'd1, 32'd3, 1'b1);
      aluOp("and", rtype(5'd2, 5'd0), 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
      aluOp("or", rtype(5'd3, 5'd0), 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0);
      aluOp("sll31", rtype(5'd4, 5'd31), 32'd1, 32'd0, 32'h8000_0000, 1'b0);
      aluOp("sra4", rtype(5'd5, 5'd4), 32'h8000_0000, 32'd0, 32'hF800_0000, 1'b0);
      aluOp("addi_ovf", itype(5'd5, 17'd1), 32'h7FFF_FFFF, 32'h55, 32'd2, 1'b1);
      aluOp("addi_neg", itype(5'd5, 17'h1FFFD), 32'd10, 32'd0, 32'd7, 1'b0);
      aluOp("lw", itype(5'd8, 17'h10), 32'h1000, 32'd0, 32'h1010, 1'b0);
      aluOp("sw", itype(5'd7, 17'h1FFFC), 32'h1000, 32'hABCD, 32'h0FFC, 1'b0);
      aluOp("setx", jtype(5'd21, 27'h123456), 32'd0, 32'd0, 32'h0012_3456, 1'b0);

      brOp("bne_taken", itype(5'd2, 17'h1FFF6), 32'd4, 32'd7, 32'd100, 1'b1, 32'd90);
      brOp("bne_not", itype(5'd2, 17'h1FFF6), 32'd7, 32'd7, 32'd100, 1'b0, 32'd0);
      brOp("blt_taken", itype(5'd6, 17'd20), 32'd5, 32'hFFFF_FFFD, 32'd200, 1'b1, 32'd220);
      brOp("blt_not", itype(5'd6, 17'd20), 32'hFFFF_FFFD, 32'd5, 32'd200, 1'b0, 32'd0);
      brOp("j", jtype(5'd1, 27'h123), 32'd0, 32'd0, 32'd100, 1'b1, 32'h123);
      brOp("jr", itype(5'd4, 17'd0), 32'd0, 32'h1234, 32'd100, 1'b1, 32'h1234);
      brOp("bex_taken", jtype(5'd22, 27'h200), 32'd1, 32'd0, 32'd100, 1'b1, 32'h200);
      brOp("bex_not", jtype(5'd22, 27'h200), 32'd0, 32'd0, 32'd100, 1'b0, 32'd0);
      applyStimulus("jal", jtype(5'd3, 27'h40), 32'd0, 32'd0, 32'd100,
                    1'b1, 32'h40, 1'b1, 32'd100, 1'b0, 32'd0);
      applyStimulus("jal_hipc", jtype(5'd3, 27'h40), 32'd0, 32'd0, 32'hF800_0010,
                    1'b1, 32'hF800_0040, 1'b1, 32'hF800_0010, 1'b0, 32'd0);

      // A bubble and a flushed branch must neither redirect nor reach X/M.
      bus.insn_in = itype(5'd2, 17'h1FFF6); bus.insn_valid = 1'b0;
      bus.regfile_a = 32'd4; bus.regfile_b = 32'd7; bus.pc_plus1 = 32'd100;
      #1;
      checkOutput("bubble.br", bus.branched_jumped, 0);
      checkOutput("bubble.pc_next", bus.pc_next, 0);
      @(posedge clock); #1;
      checkOutput("bubble.xm_valid", bus.xm_valid, 0);
      bus.insn_valid = 1'b1; bus.flush = 1'b1;
      #1;
      checkOutput("flush.br", bus.branched_jumped, 0);
      @(posedge clock); #1;
      checkOutput("flush.xm_valid", bus.xm_valid, 0);
      bus.flush = 1'b0; bus.insn_valid = 1'b0;

      // Asynchronous reset clears a freshly loaded X/M word without a clock edge.
      bus.insn_in = rtype(5'd0, 5'd0); bus.insn_valid = 1'b1;
      bus.regfile_a = 32'd2; bus.regfile_b = 32'd3;
      @(posedge clock); #1;
      bus.insn_valid = 1'b0;
      checkOutput("pre_reset.xm_valid", bus.xm_valid, 1);
      reset = 1'b1;
      #1;
      checkOutput("async_reset.xm_valid", bus.xm_valid, 0);
      checkOutput("async_reset.xm_o", bus.xm_o, 0);
      checkOutput("async_reset.xm_b", bus.xm_b, 0);
      checkOutput("async_reset.xm_insn", bus.xm_insn, 0);
      @(posedge clock); #1;
      reset = 1'b0;

`ifdef EXEC_MULDIV_EN
      runMulDiv("mul_neg", rtype(5'd6, 5'd0), 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFD6, 1'b0);
      runMulDiv("mul_ovf", rtype(5'd6, 5'd0), 32'h0001_0000, 32'h0001_0000, 32'd4, 1'b1);
      runMulDiv("mul_min", rtype(5'd6, 5'd0), 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
      runMulDiv("div_zero", rtype(5'd7, 5'd0), 32'd7, 32'd0, 32'd5, 1'b1);
      runMulDiv("div_min", rtype(5'd7, 5'd0), 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 1'b1);
      runMulDiv("div_trunc", rtype(5'd7, 5'd0), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      runMulDiv("div_pos", rtype(5'd7, 5'd0), 32'd100, 32'd7, 32'd14, 1'b0);

      bus.insn_in = rtype(5'd6, 5'd0); bus.insn_valid = 1'b1;
      bus.regfile_a = 32'd3; bus.regfile_b = 32'd5;
      #1;
      checkOutput("flush_busy.stall_c0", bus.stall, 1);
      for (int c = 1; c < 10; c++) begin
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
      bus.flush = 1'b1;
      #1;
      checkOutput("flush_busy.stall_c10", bus.stall, 0);
      @(posedge clock); #1;
      bus.flush = 1'b0;
      checkOutput("flush_busy.xm_valid", bus.xm_valid, 0);
      aluOp("addi_after_flush", itype(5'd5, 17'd3), 32'd5, 32'd0, 32'd8, 1'b0);

      bus.insn_in = rtype(5'd6, 5'd0); bus.insn_valid = 1'b1; bus.flush = 1'b1;
      #1;
      checkOutput("flush_idle.stall", bus.stall, 0);
      @(posedge clock); #1;
      bus.flush = 1'b0;
      checkOutput("flush_idle.xm_valid", bus.xm_valid, 0);
      aluOp("add_after_flush", rtype(5'd0, 5'd0), 32'd4, 32'd4, 32'd8, 1'b0);

      bus.insn_in = rtype(5'd7, 5'd0); bus.insn_valid = 1'b1;
      bus.regfile_a = 32'd9; bus.regfile_b = 32'd3;
      #1;
      checkOutput("reset_busy.stall_c0", bus.stall, 1);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clock); #1;
      end
      reset = 1'b1;
      #1;
      checkOutput("reset_busy.stall", bus.stall, 0);
      checkOutput("reset_busy.xm_valid", bus.xm_valid, 0);
      checkOutput("reset_busy.xm_o", bus.xm_o, 0);
      bus.insn_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      aluOp("add_after_reset", rtype(5'd0, 5'd0), 32'd6, 32'd1, 32'd7, 1'b0);
`else
      aluOp("mul_trap", rtype(5'd6, 5'd0), 32'hFFFF_FFFA, 32'd7, 32'd4, 1'b1);
      aluOp("div_trap", rtype(5'd7, 5'd0), 32'd7, 32'd0, 32'd5, 1'b1);
      aluOp("add_after_trap", rtype(5'd0, 5'd0), 32'd6, 32'd1, 32'd7, 1'b0);
`endif

      repeat (3) @(posedge clock);
      #1;
      checkOutput("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/execute_stage_mc.md
# execute_stage_mc

Parametrised execute stage for the five-stage pipelined processor. It sits between the D/X latch and the X/M latch and owns the X/M latch registers itself. It resolves ALU ops, branches and jumps with in-stage MX/WX bypass muxing. Multiply and divide run on an iterative multi-cycle unit that stalls upstream stages until the result is ready.

## Interface
- WIDTH, 32: data/PC width, legal range 32..64; the 17-bit immediate is sign-extended to WIDTH and the 27-bit target is zero-extended to WIDTH.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- insn_in  in  32  D/X instruction.
- insn_valid  in  1  0 = bubble; treated as a nop.
- pc_plus1  in  WIDTH  PC+1 of insn_in.
- regfile_a / regfile_b  in  WIDTH  read ports ($rs / $rd).
- o_xm_out  in  WIDTH  MX bypass source.
- data_writeReg  in  WIDTH  WX bypass source.
- byp_a / byp_b  in  2  operand source: 00 regfile, 01 WX, 10 MX; 11 behaves as 10.
- flush  in  1  squash the current instruction and abort mul/div.
- stall  out  1  hold the PC, F/D and D/X latches.
- pc_next  out  WIDTH  redirect target; valid when branched_jumped=1.
- branched_jumped  out  1  redirect this cycle (combinational).
- xm_insn  out  32  registered instruction.
- xm_o  out  WIDTH  registered result or exception code.
- xm_b  out  WIDTH  registered bypassed B (store data).
- xm_valid  out  1  registered; 0 = bubble.
- xm_exception  out  1  registered; write the code in xm_o to $rstatus.

## Operation
- Operands:
  - A = bypassed regfile_a.
  - B = bypassed regfile_b, or sext(imm[16:0]) for addi, lw and sw.
  - xm_b always carries the bypassed regfile_b.
- R-type (opcode 00000), selected by ALU op insn[6:2]:
  - add 00000, sub 00001, and 00010, or 00011.
  - sll 00100, sra 00101; shift amount is insn[11:7] masked to log2(WIDTH) bits.
  - mul 00110, div 00111.
- I-type and jumps:
  - addi 00101, sw 00111, lw 01000: A + sext(imm).
  - bne 00010: taken if A≠B.
  - blt 00110: taken if signed B<A.
  - Taken bne/blt target = pc_plus1 + sext(imm).
  - j 00001, jal 00011: target {pc_plus1[WIDTH-1:27], insn[26:0]}; jal writes o = pc_plus1.
  - jr 00100: target = B.
  - bex 10110: taken if A≠0, target as j.
  - setx 10101: o = zext(insn[26:0]).
- Exceptions: xm_exception=1 with o = code.
  - add 1, addi 2, sub 3: signed overflow.
  - mul 4: product not representable in signed WIDTH.
  - div 5: divisor 0 (quotient 0), or MIN/−1 (quotient MIN).
- Division is signed and truncates toward zero.
- branched_jumped and pc_next are combinational and forced 0 when insn_valid=0, stall=1 or flush=1.
- Mul/div FSM:
  - IDLE: a valid mul/div with flush=0 asserts stall and captures A, B and the op into internal registers.
  - IDLE -> BUSY.
  - BUSY: one shift-add (mul) or restoring (div) step per cycle on magnitudes for WIDTH cycles, with sign fixed at the end; stall stays 1.
  - BUSY -> DONE after WIDTH steps.
  - DONE: stall=0; result and exception are presented to the X/M latch.
  - DONE -> IDLE.
- Stall contents:
  - While stall=1, the X/M latch loads a bubble (xm_valid=0, xm_exception=0).
  - Bypass sources may change during stall; the captured operands are used.
- Flush:
  - In any state: FSM -> IDLE, stall=0 the same cycle, and the X/M latch loads a bubble.
  - Flush with a new mul/div present does not start it.
- Back-to-back mul/div: DONE -> IDLE; the next instruction arrives the following cycle and starts normally.
- Reset: FSM IDLE; stall 0; xm_insn, xm_o, xm_b, xm_valid and xm_exception all 0.

## Timing
- Single-cycle ops: result in the X/M latch at the first edge after presentation (latency 1).
- Mul/div:
  - Presented in cycle 0 with stall=1 in cycles 0..WIDTH.
  - DONE is cycle WIDTH+1 (stall=0); the X/M latch is written at the end of that cycle.
  - Total latency WIDTH+2 cycles; upstream holds insn_in for WIDTH+2 cycles.
- Redirect is visible in the same cycle the branch occupies X.
- Reset asserted mid-BUSY takes effect immediately, without waiting for a clock edge.

## Configuration
- EXEC_MULDIV_EN defined: iterative mul/div unit and FSM as above.
- EXEC_MULDIV_EN undefined:
  - No FSM; stall tied 0.
  - mul/div complete in one cycle with o = 4 or 5 respectively, xm_exception=1.

## Test plan
- WIDTH=32, add with A=0x7FFFFFFF, B=1 -> next edge: xm_o=1, xm_exception=1, xm_valid=1.
- byp_a=10 with o_xm_out=5, byp_b=01 with data_writeReg=3, sub -> xm_o=2; xm_b=3.
- Branches at pc_plus1=100:
  - bne with A=4, B=7, imm=−10 -> branched_jumped=1, pc_next=90.
  - jal with target 0x40 -> pc_next=0x40, xm_o=100.
- mul −6×7 -> stall high cycles 0..32, xm_o=−42 loaded at end of cycle 33, xm_exception=0.
- div 7/0 -> xm_o=5, xm_exception=1.
- div MIN/−1 -> xm_o=5, xm_exception=1.
- flush in BUSY cycle 10 -> stall drops that cycle; next xm_valid=0; the following addi completes normally.
- Reset asserted in BUSY cycle 5 -> stall=0 and all xm outputs 0 immediately.
- Rebuild with EXEC_MULDIV_EN undefined: mul gives xm_o=4 at the next edge, stall never asserted.
